// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester, configuration and uart_tx signal bundle for uart_tx_arb
interface uart_tx_arb_if #(parameter int NUM_REQ = 4);
  localparam int W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0] ack;
  logic [15:0] cfg_baud;
  logic [15:0] uart_cnt;
  logic uart_flag;
  logic [7:0] uart_data;
  logic uart_busy;
  logic tx_done;
  logic [W-1:0] tx_owner;
  logic start_err;
  modport master (
    output req, req_data, cfg_baud, uart_busy,
    input  ack, uart_cnt, uart_flag, uart_data, tx_done, tx_owner, start_err
  );
  modport slave (
    input  req, req_data, cfg_baud, uart_busy,
    output ack, uart_cnt, uart_flag, uart_data, tx_done, tx_owner, start_err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one uart_tx among NUM_REQ byte producers
module uart_tx_arb #(
  parameter int NUM_REQ  = 4,
  parameter int GAP_CYC  = 2,
  parameter int START_TO = 8
) (
  input logic clk,
  input logic rst,
  uart_tx_arb_if.slave bus
);
  localparam int W = $clog2(NUM_REQ);
  localparam logic [7:0] START_LAST = 8'(START_TO - 1);
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  localparam state_t POST = (GAP_CYC == 0) ? IDLE : GAP;
  state_t state;
  logic [W-1:0] ptr, win;
  logic found;
  logic [7:0] cnt;
  // first set request strictly after the last winner, wrapping around
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++)
      if (!found && bus.req[W'((int'(ptr) + i) % NUM_REQ)]) begin
        win = W'((int'(ptr) + i) % NUM_REQ);
        found = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= W'(NUM_REQ - 1);
      cnt <= '0;
      bus.ack <= '0;
      bus.uart_flag <= 1'b0;
      bus.uart_data <= '0;
      bus.tx_done <= 1'b0;
      bus.start_err <= 1'b0;
      bus.tx_owner <= '0;
      bus.uart_cnt <= 16'd100;
    end else begin
      bus.ack <= '0;
      bus.uart_flag <= 1'b0;
      bus.tx_done <= 1'b0;
      bus.start_err <= 1'b0;
      case (state)
        IDLE: begin
          bus.uart_cnt <= bus.cfg_baud;
          if (found && !bus.uart_busy) begin
            bus.ack <= NUM_REQ'(1) << win;
            bus.uart_data <= bus.req_data[8*win +: 8];
            bus.tx_owner <= win;
            ptr <= win;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.uart_flag <= 1'b1;
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY:
          if (bus.uart_busy) state <= WAIT_DONE;
          else if (cnt == START_LAST) begin
            bus.start_err <= 1'b1;
            cnt <= '0;
            state <= POST;
          end else cnt <= cnt + 8'd1;
        WAIT_DONE:
          if (!bus.uart_busy) begin
            bus.tx_done <= 1'b1;
            cnt <= '0;
            state <= POST;
          end
        GAP: begin
          cnt <= cnt + 8'd1;
          state <= (cnt == GAP_LAST) ? IDLE : GAP;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: vector table, corner sequences and random traffic against a timestamp model
module tb_uart_tx_arb;
  localparam int NR = 4, GAP = 2, STO = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arb_if #(.NUM_REQ(NR)) bus();
  uart_tx_arb #(.NUM_REQ(NR), .GAP_CYC(GAP), .START_TO(STO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic [NR-1:0] req;
    logic [31:0] data;
    logic [NR-1:0] ack;
    logic [7:0] byte_out;
  } vec_t;
  vec_t tab[10];
  int checks = 0, errors = 0, t = 0;
  bit m_idle, seen_busy;
  int ready_at, flag_at, m_ptr, m_owner;
  logic [7:0] m_data;
  logic [15:0] m_cnt;
  bit rnd_on, dead;
  int start_dly, frame_len, b_start, b_end, ack2_seen, n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, t, act, want);
    end
  endtask

  // winner = set requester with the smallest circular distance after the last winner
  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    int best = -1, bd = NR;
    for (int i = 0; i < NR; i++)
      if (r[i]) begin
        int d = (i - p - 1 + 2 * NR) % NR;
        if (d < bd) begin bd = d; best = i; end
      end
    return best;
  endfunction

  task automatic model_reset();
    m_idle = 1; seen_busy = 0; ready_at = 0; flag_at = -1;
    m_ptr = NR - 1; m_owner = 0; m_data = 8'h00; m_cnt = 16'd100;
    b_start = 0; b_end = 0;
  endtask

  task automatic cyc();
    logic [NR-1:0] e_ack = '0;
    bit e_flag = 0, e_done = 0, e_err = 0;
    int w;
    @(posedge clk); #1; t++;
    if (m_idle) begin
      if (t >= ready_at) begin
        m_cnt = bus.cfg_baud;
        if (bus.req != 0 && !bus.uart_busy) begin
          w = rr_pick(bus.req, m_ptr);
          e_ack = NR'(1) << w;
          m_data = bus.req_data[8*w +: 8];
          m_owner = w; m_ptr = w; m_idle = 0; seen_busy = 0; flag_at = t + 1;
        end
      end
    end else if (t == flag_at) e_flag = 1;
    else if (!seen_busy) begin
      if (bus.uart_busy) seen_busy = 1;
      else if (t == flag_at + STO) begin e_err = 1; m_idle = 1; ready_at = t + GAP + 1; end
    end else if (!bus.uart_busy) begin e_done = 1; m_idle = 1; ready_at = t + GAP + 1; end
    chk("ack", bus.ack, e_ack);
    chk("uart_flag", bus.uart_flag, e_flag);
    chk("uart_data", bus.uart_data, m_data);
    chk("tx_done", bus.tx_done, e_done);
    chk("start_err", bus.start_err, e_err);
    chk("tx_owner", bus.tx_owner, m_owner);
    chk("uart_cnt", bus.uart_cnt, m_cnt);
    if (bus.ack[2]) ack2_seen++;
    if (bus.uart_flag) begin
      if (rnd_on) begin
        dead = ($urandom_range(0, 9) == 0);
        start_dly = $urandom_range(0, 3);
        frame_len = $urandom_range(1, 12);
      end
      b_start = dead ? 0 : t + start_dly;
      b_end = dead ? 0 : b_start + frame_len;
    end
    bus.uart_busy = (t >= b_start && t < b_end) ||
                    (rnd_on && m_idle && t >= b_end && $urandom_range(0, 7) == 0);
    if (rnd_on) begin
      for (int i = 0; i < NR; i++)
        if (bus.ack[i]) begin
          bus.req[i] = 1'($urandom_range(0, 1));
          bus.req_data[8*i +: 8] = 8'($urandom);
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            bus.req[i] = 1'b1;
            bus.req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 60) == 0) bus.req[i] = 1'b0;
      if ($urandom_range(0, 15) == 0) bus.cfg_baud = 16'($urandom);
    end
  endtask

  task automatic wait_ack(input int lim);
    int k = 0;
    do begin cyc(); k++; end while (bus.ack == 0 && k < lim);
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    do begin cyc(); k++; end while (!bus.tx_done && k < lim);
    chk("done_seen", bus.tx_done, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_flag"}, bus.uart_flag, 0);
    chk({tag, "_data"}, bus.uart_data, 0);
    chk({tag, "_done"}, bus.tx_done, 0);
    chk({tag, "_err"}, bus.start_err, 0);
    chk({tag, "_owner"}, bus.tx_owner, 0);
    chk({tag, "_cnt"}, bus.uart_cnt, 100);
  endtask

  initial begin
    tab[0] = '{4'b0010, 32'h0000AF00, 4'b0010, 8'hAF};
    tab[1] = '{4'b1111, 32'h13121110, 4'b0100, 8'h12};
    tab[2] = '{4'b1011, 32'h23222120, 4'b1000, 8'h23};
    tab[3] = '{4'b1111, 32'h33323130, 4'b0001, 8'h30};
    tab[4] = '{4'b0001, 32'h00000041, 4'b0001, 8'h41};
    tab[5] = '{4'b1000, 32'h52000000, 4'b1000, 8'h52};
    tab[6] = '{4'b0110, 32'h00636200, 4'b0010, 8'h62};
    tab[7] = '{4'b0101, 32'h00730070, 4'b0100, 8'h73};
    tab[8] = '{4'b0011, 32'h00008180, 4'b0001, 8'h80};
    tab[9] = '{4'b1100, 32'h93920000, 4'b0100, 8'h92};
    bus.req = '0; bus.req_data = '0; bus.cfg_baud = 16'd100; bus.uart_busy = 1'b0;
    rnd_on = 0; dead = 0; start_dly = 1; frame_len = 5; ack2_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.req = tab[k].req;
      bus.req_data = tab[k].data;
      wait_ack(40);
      chk("tab_ack", bus.ack, tab[k].ack);
      bus.req = '0;
      cyc();
      chk("tab_launch", {bus.uart_flag, bus.uart_data}, {1'b1, tab[k].byte_out});
      wait_done(60);
    end
    // baud divisor frozen while a frame is in flight
    frame_len = 20;
    bus.req = 4'b0001;
    wait_ack(40);
    bus.req = '0;
    repeat (6) cyc();
    bus.cfg_baud = 16'd50;
    cyc();
    chk("baud_frozen", bus.uart_cnt, 100);
    wait_done(60);
    repeat (GAP) cyc();
    chk("baud_gap", bus.uart_cnt, 100);
    cyc();
    chk("baud_new", bus.uart_cnt, 50);
    // uart_tx never answers
    dead = 1;
    bus.req = 4'b0100;
    wait_ack(40);
    bus.req = '0;
    cyc();
    chk("to_flag", bus.uart_flag, 1);
    n = 0;
    do begin cyc(); n++; end while (!bus.start_err && n < 3 * STO);
    chk("start_to_lat", n, STO);
    dead = 0;
    bus.req = 4'b1000;
    wait_ack(40);
    chk("after_to_ack", bus.ack, 4'b1000);
    bus.req = '0;
    wait_done(60);
    // requester 2 withdraws before the arbiter is back in IDLE
    frame_len = 10;
    bus.req = 4'b0001;
    wait_ack(40);
    bus.req = '0;
    ack2_seen = 0;
    repeat (4) cyc();
    bus.req = 4'b0100; bus.req_data = 32'h00CC0000;
    repeat (3) cyc();
    bus.req = '0;
    wait_done(60);
    repeat (GAP + 3) cyc();
    bus.req = 4'b0010; bus.req_data = 32'h0000DD00;
    wait_ack(40);
    chk("wd_ack", bus.ack, 4'b0010);
    chk("wd_no_ack2", ack2_seen, 0);
    bus.req = '0;
    wait_done(60);
    // asynchronous reset in the middle of a frame
    frame_len = 20;
    bus.req = 4'b0100; bus.req_data = 32'h00EE0000;
    wait_ack(40);
    bus.req = '0;
    repeat (5) cyc();
    #3 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    bus.uart_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.req = 4'b1111; bus.req_data = 32'h44332211;
    wait_ack(40);
    chk("rst_prio", bus.ack, 4'b0001);
    rnd_on = 1;
    repeat (3000) cyc();
    rnd_on = 0; dead = 0;
    bus.req = '0;
    repeat (40) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
